// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end feeding decode.
//
// Owns the fetch PC, issues one word read at a time to instruction memory
// (req/ack), buffers returned words tagged with their PC in a DEPTH-entry
// FIFO, and hands them to decode over valid/ready. A redirect flushes the
// buffer and restarts fetch at the new target; if a read is still in flight
// the unit waits for its ack (DRAIN), discards it, then fetches the target.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   imem_req, imem_addr    read request and word-aligned byte address
//   imem_ack, imem_data    read completion and returned word
//   instr_valid, instr,    FIFO head: valid flag, word, and its PC
//   instr_pc, instr_ready  decode accepts head when valid && ready
//   redirect, redirect_pc  one-cycle flush pulse and new fetch target
module fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {FETCH, DRAIN} state_t;

    state_t             state;
    logic [31:0]        fetch_pc;
    logic [31:0]        pend_pc;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;
    logic [31:0]        pc_mem   [DEPTH];
    logic [31:0]        word_mem [DEPTH];

    logic               xfer;
    logic               pop;
    logic               push;
    logic [31:0]        target;

    always_comb begin
        imem_req    = !reset && (((state == FETCH) && (count < CNT_W'(DEPTH)))
                                 || (state == DRAIN));
        imem_addr   = fetch_pc;
        instr_valid = (count != '0);
        instr       = word_mem[head];
        instr_pc    = pc_mem[head];
        xfer        = imem_req && imem_ack;
        pop         = instr_valid && instr_ready;
        // Acks seen in DRAIN or alongside a redirect belong to a stale stream.
        push        = (state == FETCH) && xfer && !redirect;
        target      = {redirect_pc[31:2], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]   <= fetch_pc;
            word_mem[tail] <= imem_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            pend_pc  <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            // FIFO bookkeeping: a flush overrides any push/pop this cycle.
            if (redirect) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push)
                    tail <= tail + 1'b1;
                if (pop)
                    head <= head + 1'b1;
                if (push && !pop)
                    count <= count + 1'b1;
                else if (!push && pop)
                    count <= count - 1'b1;
            end

            case (state)
                FETCH: begin
                    if (redirect) begin
                        if (xfer || !imem_req) begin
                            fetch_pc <= target;
                        end else begin
                            // Request in flight: keep it on the bus until acked.
                            pend_pc <= target;
                            state   <= DRAIN;
                        end
                    end else if (xfer) begin
                        fetch_pc <= fetch_pc + 32'd4;
                    end
                end
                DRAIN: begin
                    if (redirect)
                        pend_pc <= target;
                    if (xfer) begin
                        // A redirect coinciding with the stale ack takes priority.
                        fetch_pc <= redirect ? target : pend_pc;
                        state    <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end that sits directly upstream of instruction decode. It owns the fetch PC and issues word reads to instruction memory over a req/ack handshake, with at most one request outstanding. Returned words are buffered, each tagged with its PC, in a small FIFO. The decode stage drains the FIFO through a valid/ready interface. Branch and jump redirects flush the buffer and restart fetch at the new target, including when a memory read is still in flight.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: fetch PC loaded on reset; bits [1:0] must be 0.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  read request to instruction memory.
- `imem_addr`  out  32  byte address of the read; always word-aligned.
- `imem_ack`  in  1  memory completes the request; `imem_data` is valid in this cycle.
- `imem_data`  in  32  instruction word.
- `instr_valid`  out  1  FIFO head holds an instruction.
- `instr`  out  32  instruction word at the FIFO head.
- `instr_pc`  out  32  PC of the FIFO head.
- `instr_ready`  in  1  decode accepts the head this cycle.
- `redirect`  in  1  one-cycle pulse: flush and refetch.
- `redirect_pc`  in  32  redirect target; bits [1:0] are ignored and forced to 0.

## Operation
- State: `fetch_pc`, `pend_pc`, FIFO storage `{pc, word}`×DEPTH, head pointer, tail pointer, count (0..DEPTH), and FSM ∈ {FETCH, DRAIN}.
- Reset (async): `fetch_pc`=RESET_PC, `pend_pc`=0, pointers=0, count=0, FSM=FETCH.
- Outputs during reset: `imem_req`=0, `instr_valid`=0, `imem_addr`=RESET_PC. `instr` and `instr_pc` are don't-care.
- `imem_addr` = `fetch_pc` at all times.
- `imem_req` = !reset && ((FETCH && count<DEPTH) || DRAIN).
- Memory handshake: a transfer completes on a cycle with `imem_req` && `imem_ack`. Once `imem_req` rises, it and `imem_addr` hold stable until that cycle.
- FETCH, ack, no redirect:
  - Push `{fetch_pc, imem_data}` at the tail.
  - `fetch_pc` += 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- FETCH, redirect, with ack or with `imem_req`=0:
  - Count=0, pointers=0.
  - `fetch_pc` = {`redirect_pc`[31:2], 2'b00}.
  - Acked data is dropped. FSM stays FETCH.
- FETCH, redirect, `imem_req`=1 and no ack:
  - Flush the FIFO.
  - `pend_pc` = aligned `redirect_pc`.
  - FSM → DRAIN. `imem_req`/`imem_addr` keep the old request.
- DRAIN:
  - On ack: discard the data, `fetch_pc` = `pend_pc`, FSM → FETCH.
  - A redirect in DRAIN overwrites `pend_pc`. If it coincides with the ack, the new target wins.
- Pop: `instr_valid` && `instr_ready` → head advances, count−1.
- Push and pop in the same cycle: count unchanged.
- Redirect and pop in the same cycle: the popped instruction counts as consumed; the flush wins for FIFO state.
- Push never targets a full FIFO: a request is only raised with count<DEPTH, and only acks increment count.
- `instr_valid` = (count≠0). `instr` and `instr_pc` come combinationally from the head entry.

## Timing
- Ack at cycle N → entry visible (`instr_valid`=1) at N+1.
- First `imem_req` occurs in the first cycle after `reset` falls, with `imem_addr`=RESET_PC.
- With `imem_ack` tied high and `instr_ready` high, throughput is 1 instr/cycle and `imem_addr` increments by 4 every cycle.
- With `instr_ready` low, fetch stalls after DEPTH acks. `imem_req` falls in the cycle after the DEPTH-th ack, and rises again the cycle after a pop.
- Redirect at cycle N:
  - `instr_valid`=0 at N+1.
  - In FETCH, the new target is on `imem_addr` with `imem_req` at N+1.
  - In DRAIN, the new target appears the cycle after the stale ack.
- Reset asserted mid-transfer: everything clears immediately. The memory must tolerate an abandoned request.

## Test plan
- Reset with RESET_PC=0x100, ack tied 1, ready 1 → `instr_pc` sequence 0x100, 0x104, 0x108…; `instr_valid` first high one cycle after the first req.
- ready=0 with ack tied 1 → exactly 4 acks, `imem_req` low, head = 0x100 held. Raising ready for one cycle → exactly one more fetch.
- Redirect to 0x2003 while idle-full → FIFO empties next cycle; `imem_addr`=0x2000; first delivered `instr_pc`=0x2000.
- Memory with 3-cycle ack latency; redirect to 0x400 one cycle after req at 0x10 → req/addr 0x10 held until ack, that word is never delivered, next req addr=0x400.
- Two redirects (0x400 then 0x800) during DRAIN, second coincident with ack → next req 0x800; no 0x10 or 0x400 words delivered.
- `fetch_pc`=0xFFFF_FFFC, ack → next `imem_addr`=0x0; async reset pulse mid-request → `imem_req`=0 and `instr_valid`=0 without a clock edge.
